// File: rtl/regfile_mp_clr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_clr
// Purpose  : Multi-read-port register file with lane-masked writes,
//            write-to-read bypass and a sequential row-clear engine.
//            After reset or a clear request the file zeroes one row per
//            clock (rows 1..DEPTH-1) and raises ready when done. Row 0 is
//            hardwired to zero. Storage has one write port and asynchronous
//            reads, so it maps to inferred RAM.
// Optional : `define PARITY_EN adds one even-parity bit per lane per row and
//            the perr output port.
// Ports    : clk      - clock
//            reset    - synchronous, active-high reset
//            clr_req  - pulse, restart a full clear
//            raddr    - NRD read addresses, port p at raddr[p*AW +: AW]
//            rdata    - NRD read data words, port p at rdata[p*WIDTH +: WIDTH]
//            waddr    - write address
//            wdata    - write data
//            wr_en    - write enable
//            ppp      - write participation mode
//            ready    - 1 when the file is usable (IDLE)
//            perr     - per-port parity error (PARITY_EN builds only)
// Bit order: the architectural numbering counts bit 0 as the MSB. Vectors
//            here are declared [N-1:0], so architectural bit i is vector bit
//            N-1-i and lane k (counted from the MSB) is
//            [WIDTH-1-k*LANE -: LANE].
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_clr #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 64,
  parameter int LANE  = 8,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_req,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 wr_en,
  input  logic [2:0]           ppp,
  output logic                 ready
`ifdef PARITY_EN
  ,
  output logic [NRD-1:0]       perr
`endif
);

  localparam int NL = WIDTH / LANE;
  // One bit wider than an address so the range check never degenerates.
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  generate
    if ((WIDTH % (2*LANE)) != 0) begin : g_bad_width
      $error("regfile_mp_clr: WIDTH must be a multiple of 2*LANE");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q,   cnt_d;
  logic            ready_q, ready_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Lane participation vector; bit k is lane k counted from the MSB.
  function automatic logic [NL-1:0] lane_sel(input logic [2:0] mode);
    logic [NL-1:0] s;
    s = '0;
    for (int k = 0; k < NL; k++) begin
      case (mode)
        3'b000:  s[k] = 1'b1;
        3'b001:  s[k] = (k < NL/2);
        3'b010:  s[k] = (k >= NL/2);
        3'b011:  s[k] = ((k % 2) == 0);
        3'b100:  s[k] = ((k % 2) == 1);
        default: s[k] = 1'b0;
      endcase
    end
    return s;
  endfunction

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_X);
  endfunction

`ifdef PARITY_EN
  function automatic logic [NL-1:0] par_of(input logic [WIDTH-1:0] row);
    logic [NL-1:0] p;
    p = '0;
    for (int k = 0; k < NL; k++) begin
      p[k] = ^row[WIDTH-1-k*LANE -: LANE];
    end
    return p;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_req) begin
          cnt_d = AW'(1);
        end else if (cnt_q == AW'(DEPTH-1)) begin
          // Last row is cleared on this edge; file becomes usable with it.
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = AW'(1);
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = AW'(1);
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

  // --------------------------------------------------------------------------
  // Write path: a single RAM write port shared by the clear engine and the
  // normal write. The merged word is also what the bypass returns.
  // --------------------------------------------------------------------------
  logic [NL-1:0]    wlanes;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wr_merge;
  logic             wr_active;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  always_comb begin
    wlanes = lane_sel(ppp);
    wmask  = '0;
    for (int k = 0; k < NL; k++) begin
      wmask[WIDTH-1-k*LANE -: LANE] = {LANE{wlanes[k]}};
    end
  end

  assign wr_merge  = (mem_q[waddr] & ~wmask) | (wdata & wmask);
  // Bypass-visible write: IDLE and enabled; address checks happen per port.
  assign wr_active = (state_q == ST_IDLE) && wr_en;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt_q;
    mem_wd = '0;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
      end else if (wr_en && !clr_req && addr_ok(waddr) && (|wlanes)) begin
        // A clear request in the same cycle wins over the write.
        mem_we = 1'b1;
        mem_wa = waddr;
        mem_wd = wr_merge;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

`ifdef PARITY_EN
  logic [NL-1:0] par_q [DEPTH];
  logic [NL-1:0] par_wd;

  // Only participating lanes refresh their parity bit; the others keep the
  // stored bit so a latent corruption in an untouched lane stays visible.
  always_comb begin
    par_wd = '0;
    if (state_q == ST_IDLE) begin
      par_wd = (par_q[waddr] & ~wlanes) | (par_of(wdata) & wlanes);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_q[mem_wa] <= par_wd;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read ports (asynchronous)
  // --------------------------------------------------------------------------
  always_comb begin
    logic [AW-1:0] ra;
    rdata = '0;
`ifdef PARITY_EN
    perr  = '0;
`endif
    for (int p = 0; p < NRD; p++) begin
      ra = raddr[p*AW +: AW];
      if ((state_q == ST_IDLE) && addr_ok(ra)) begin
        if (wr_active && (waddr == ra)) begin
          rdata[p*WIDTH +: WIDTH] = wr_merge;
        end else begin
          rdata[p*WIDTH +: WIDTH] = mem_q[ra];
        end
`ifdef PARITY_EN
        // Checked against the stored row, never the bypassed word.
        perr[p] = |(par_of(mem_q[ra]) ^ par_q[ra]);
`endif
      end
    end
  end

endmodule
`default_nettype wire
